// File: rtl/l1_mult_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// l1_mult_seq_ctrl_pkg
// Purpose : shared types and helpers for the L1 multiplier sequencer.
//           Provides the sequencer state encoding, the operand precision
//           codes and the number of 4x4 nibble passes each precision needs.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package l1_mult_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [1:0] PREC_8X8 = 2'b00;
   localparam logic [1:0] PREC_8X4 = 2'b01;
   localparam logic [1:0] PREC_RSV = 2'b10;
   localparam logic [1:0] PREC_4X4 = 2'b11;

   // Reserved code behaves as 4x4.
   function automatic logic [2:0] get_npass(input logic [1:0] prec);
      case (prec)
         PREC_8X8: get_npass = 3'd4;
         PREC_8X4: get_npass = 3'd2;
         default:  get_npass = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/l1_mult_seq_ctrl_pass_sel.sv
// ----------------------------------------------------------------------------
// l1_pass_sel
// Purpose : combinational nibble/shift selector. For a given precision and
//           pass index it picks which activation and weight nibbles feed the
//           4x4 multiplier and how far the product is shifted before it is
//           added to the accumulator.
// Ports   : i_prec[1:0]      operand precision code
//           i_pass_cnt[1:0]  current pass index
//           i_a[7:0]         latched activation
//           i_w[7:0]         latched weight
//           o_mult_a[3:0]    activation nibble
//           o_mult_w[3:0]    weight nibble
//           o_shift[3:0]     left shift applied to the partial product
// ----------------------------------------------------------------------------
module l1_pass_sel
   import l1_mult_seq_ctrl_pkg::*;
(
   input  logic [1:0] i_prec,
   input  logic [1:0] i_pass_cnt,
   input  logic [7:0] i_a,
   input  logic [7:0] i_w,
   output logic [3:0] o_mult_a,
   output logic [3:0] o_mult_w,
   output logic [3:0] o_shift
);

   always_comb begin
      o_mult_a = i_a[3:0];
      o_mult_w = i_w[3:0];
      o_shift  = 4'd0;
      case (i_prec)
         // Pass order: aL*wL, aH*wL, aL*wH, aH*wH -> bit0 picks the a
         // nibble, bit1 picks the w nibble.
         PREC_8X8: begin
            o_mult_a = i_pass_cnt[0] ? i_a[7:4] : i_a[3:0];
            o_mult_w = i_pass_cnt[1] ? i_w[7:4] : i_w[3:0];
            case (i_pass_cnt)
               2'd0:    o_shift = 4'd0;
               2'd3:    o_shift = 4'd8;
               default: o_shift = 4'd4;
            endcase
         end
         PREC_8X4: begin
            o_mult_a = i_pass_cnt[0] ? i_a[7:4] : i_a[3:0];
            o_shift  = i_pass_cnt[0] ? 4'd4 : 4'd0;
         end
         PREC_4X4, PREC_RSV: begin
            o_mult_a = i_a[3:0];
            o_mult_w = i_w[3:0];
            o_shift  = 4'd0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/l1_mult_seq_ctrl.sv
// ----------------------------------------------------------------------------
// l1_mult_seq_ctrl
// Purpose : sequencer for one 4x4 precision-scalable L1 multiplier. Accepts
//           8b activation/weight pairs, runs each pair through 1, 2 or 4
//           nibble passes, shift-accumulates the partial products into a dot
//           product of cfg_len+1 elements and hands the sum out on a
//           valid/ready port.
// Ports   : clk, rst_n            clock, asynchronous active-low reset
//           cfg_prec[1:0]         00 8x8, 01 8a x 4w, 11/10 4x4
//           cfg_len[LEN_W-1:0]    elements per dot product minus one
//           in_valid/in_ready     operand pair handshake
//           in_a[7:0], in_w[7:0]  unsigned activation / weight
//           mult_a, mult_w [3:0]  nibbles to the multiplier (0 outside PASS)
//           mult_prec[1:0]        multiplier mode, always 4x4
//           mult_z[7:0]           combinational product from the multiplier
//           out_valid/out_ready   result handshake
//           out_sum[ACC_W-1:0]    dot product, wraps modulo 2^ACC_W
//           busy                  not idle, or a vector is partially summed
// ----------------------------------------------------------------------------
module l1_mult_seq_ctrl
   import l1_mult_seq_ctrl_pkg::*;
#(
   parameter int ACC_W = 24,
   parameter int LEN_W = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       cfg_prec,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_w,
   output logic [3:0]       mult_a,
   output logic [3:0]       mult_w,
   output logic [1:0]       mult_prec,
   input  logic [7:0]       mult_z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             busy
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_pass_cnt;
   logic [LEN_W-1:0] r_elem_cnt;
   logic [LEN_W-1:0] r_len;
   logic [1:0]       r_prec;
   logic [7:0]       r_a;
   logic [7:0]       r_w;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_out_sum;

   logic [2:0]       w_npass;
   logic             w_last_pass;
   logic             w_last_elem;
   logic             w_accept;
   logic [3:0]       w_sel_a;
   logic [3:0]       w_sel_w;
   logic [3:0]       w_shift;
   logic [ACC_W-1:0] w_acc_sum;

   // Zero-extend the 8b product to accumulator width, then align it.
   function automatic logic [ACC_W-1:0] align_pp(input logic [7:0] z,
                                                 input logic [3:0] sh);
      align_pp = {{(ACC_W-8){1'b0}}, z} << sh;
   endfunction

   l1_pass_sel u_pass_sel (
      .i_prec     (r_prec),
      .i_pass_cnt (r_pass_cnt),
      .i_a        (r_a),
      .i_w        (r_w),
      .o_mult_a   (w_sel_a),
      .o_mult_w   (w_sel_w),
      .o_shift    (w_shift)
   );

   assign w_npass     = get_npass(r_prec);
   assign w_last_pass = ({1'b0, r_pass_cnt} == (w_npass - 3'd1));
   assign w_last_elem = (r_elem_cnt == r_len);
   assign w_accept    = in_valid & in_ready;
   assign w_acc_sum   = r_acc + align_pp(mult_z, w_shift);

   // ---- state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // ---- next-state logic ----
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = ST_PASS;
         ST_PASS: begin
            if (w_last_pass) begin
               if (w_last_elem)   w_state_nxt = ST_HOLD;
               else if (w_accept) w_state_nxt = ST_PASS;
               else               w_state_nxt = ST_IDLE;
            end
         end
         ST_HOLD: if (out_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---- output logic ----
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      mult_a    = 4'd0;
      mult_w    = 4'd0;
      case (r_state)
         ST_IDLE: in_ready = 1'b1;
         ST_PASS: begin
            mult_a   = w_sel_a;
            mult_w   = w_sel_w;
            // Opening the input in the last pass lets the next element
            // start without a bubble.
            in_ready = w_last_pass & ~w_last_elem;
         end
         ST_HOLD: out_valid = 1'b1;
         default: ;
      endcase
   end

   assign mult_prec = 2'b00;
   assign out_sum   = r_out_sum;
   assign busy      = (r_state != ST_IDLE) || (r_elem_cnt != '0);

   // ---- counters, configuration and accumulator ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pass_cnt <= 2'd0;
         r_elem_cnt <= '0;
         r_len      <= '0;
         r_prec     <= PREC_8X8;
         r_acc      <= '0;
         r_out_sum  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_pass_cnt <= 2'd0;
                  // Configuration is sampled only at the first element so
                  // mid-vector changes cannot disturb the running sum.
                  if (r_elem_cnt == '0) begin
                     r_prec <= cfg_prec;
                     r_len  <= cfg_len;
                  end
               end
            end
            ST_PASS: begin
               r_acc <= w_acc_sum;
               if (w_last_pass) begin
                  r_pass_cnt <= 2'd0;
                  if (w_last_elem) r_out_sum  <= w_acc_sum;
                  else             r_elem_cnt <= r_elem_cnt + LEN_W'(1);
               end else begin
                  r_pass_cnt <= r_pass_cnt + 2'd1;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  r_acc      <= '0;
                  r_elem_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // ---- operand capture (data only, no reset needed: gated outside PASS) ----
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= in_a;
         r_w <= in_w;
      end
   end

endmodule

// File: tb/tb_l1_mult_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_l1_mult_seq_ctrl
// Purpose : directed self-checking bench. Two sequencers (ACC_W=24 default
//           and ACC_W=16) share all stimulus; each drives its own behavioural
//           4x4 multiplier. Stimulus is applied and outputs sampled on the
//           falling clock edge.
// ----------------------------------------------------------------------------
module tb_l1_mult_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic [1:0]  cfg_prec;
   logic [7:0]  cfg_len;
   logic        in_valid;
   logic [7:0]  in_a;
   logic [7:0]  in_w;
   logic        out_ready;

   logic        in_ready_a,  in_ready_b;
   logic [3:0]  mult_a_a,    mult_a_b;
   logic [3:0]  mult_w_a,    mult_w_b;
   logic [1:0]  mult_prec_a, mult_prec_b;
   logic [7:0]  mult_z_a,    mult_z_b;
   logic        out_valid_a, out_valid_b;
   logic [23:0] out_sum_a;
   logic [15:0] out_sum_b;
   logic        busy_a,      busy_b;

   int total;
   int bad;

   assign mult_z_a = {4'b0, mult_a_a} * {4'b0, mult_w_a};
   assign mult_z_b = {4'b0, mult_a_b} * {4'b0, mult_w_b};

   l1_mult_seq_ctrl dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_prec  (cfg_prec),
      .cfg_len   (cfg_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a),
      .in_a      (in_a),
      .in_w      (in_w),
      .mult_a    (mult_a_a),
      .mult_w    (mult_w_a),
      .mult_prec (mult_prec_a),
      .mult_z    (mult_z_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready),
      .out_sum   (out_sum_a),
      .busy      (busy_a)
   );

   l1_mult_seq_ctrl #(.ACC_W(16)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_prec  (cfg_prec),
      .cfg_len   (cfg_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready_b),
      .in_a      (in_a),
      .in_w      (in_w),
      .mult_a    (mult_a_b),
      .mult_w    (mult_w_b),
      .mult_prec (mult_prec_b),
      .mult_z    (mult_z_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready),
      .out_sum   (out_sum_b),
      .busy      (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_a = 8'd0; in_w = 8'd0;
      cfg_prec = 2'b11; cfg_len = 8'd0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_a); end
      total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_a); end
      total++; if (out_sum_a !== 24'd0) begin bad++; $display("FAIL reset_out_sum got=%0d exp=0", out_sum_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
      total++; if ({mult_a_a, mult_w_a} !== 8'h00) begin bad++; $display("FAIL reset_mult got=%h/%h exp=0/0", mult_a_a, mult_w_a); end
      total++; if (mult_prec_a !== 2'b00) begin bad++; $display("FAIL reset_mult_prec got=%b exp=00", mult_prec_a); end
      total++; if ({in_ready_b, out_valid_b, busy_b, mult_prec_b} !== 5'b10000 || out_sum_b !== 16'd0)
         begin bad++; $display("FAIL reset_dut16 got rdy=%b v=%b busy=%b sum=%0d", in_ready_b, out_valid_b, busy_b, out_sum_b); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // T1: 4x4, single element, result two cycles after the accept edge.
   task automatic test_prec4x4();
      cfg_prec = 2'b11; cfg_len = 8'd0;
      in_valid = 1'b1; in_a = 8'h0F; in_w = 8'h0F;
      total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL t1_ready_idle got=%b exp=1", in_ready_a); end
      @(negedge clk);
      in_valid = 1'b0;
      total++; if ({mult_a_a, mult_w_a} !== 8'hFF || out_valid_a !== 1'b0 || in_ready_a !== 1'b0)
         begin bad++; $display("FAIL t1_pass got a=%h w=%h v=%b rdy=%b exp f f 0 0", mult_a_a, mult_w_a, out_valid_a, in_ready_a); end
      @(negedge clk);
      total++; if (out_valid_a !== 1'b1 || out_sum_a !== 24'd225)
         begin bad++; $display("FAIL t1_result got v=%b sum=%0d exp v=1 sum=225", out_valid_a, out_sum_a); end
      total++; if ({mult_a_a, mult_w_a} !== 8'h00 || in_ready_a !== 1'b0)
         begin bad++; $display("FAIL t1_hold_gate got a=%h w=%h rdy=%b exp 0 0 0", mult_a_a, mult_w_a, in_ready_a); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b1)
         begin bad++; $display("FAIL t1_release got v=%b busy=%b rdy=%b exp 0 0 1", out_valid_a, busy_a, in_ready_a); end
   endtask

   // T2: 8x8, four passes; all-ones vector then a vector with distinct nibbles.
   task automatic test_prec8x8();
      logic [3:0] exp_a [4];
      logic [3:0] exp_w [4];
      cfg_prec = 2'b00; cfg_len = 8'd0;
      in_valid = 1'b1; in_a = 8'hFF; in_w = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         total++; if ({mult_a_a, mult_w_a} !== 8'hFF || out_valid_a !== 1'b0)
            begin bad++; $display("FAIL t2_ff_pass%0d got a=%h w=%h v=%b exp f f 0", k, mult_a_a, mult_w_a, out_valid_a); end
         @(negedge clk);
      end
      total++; if (out_valid_a !== 1'b1 || out_sum_a !== 24'd65025)
         begin bad++; $display("FAIL t2_ff_result got v=%b sum=%0d exp v=1 sum=65025", out_valid_a, out_sum_a); end
      total++; if (out_sum_b !== 16'd65025)
         begin bad++; $display("FAIL t2_ff_result16 got=%0d exp=65025", out_sum_b); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      exp_a[0] = 4'h2; exp_a[1] = 4'h1; exp_a[2] = 4'h2; exp_a[3] = 4'h1;
      exp_w[0] = 4'h4; exp_w[1] = 4'h4; exp_w[2] = 4'h3; exp_w[3] = 4'h3;
      in_valid = 1'b1; in_a = 8'h12; in_w = 8'h34;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         total++; if (mult_a_a !== exp_a[k] || mult_w_a !== exp_w[k] || mult_prec_a !== 2'b00)
            begin bad++; $display("FAIL t2_sched_pass%0d got a=%h w=%h p=%b exp a=%h w=%h p=00", k, mult_a_a, mult_w_a, mult_prec_a, exp_a[k], exp_w[k]); end
         @(negedge clk);
      end
      total++; if (out_valid_a !== 1'b1 || out_sum_a !== 24'd936)
         begin bad++; $display("FAIL t2_sched_result got v=%b sum=%0d exp v=1 sum=936", out_valid_a, out_sum_a); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // T3: 8a x 4w, four back-to-back elements 200*15 -> 12000.
   task automatic test_back_to_back();
      logic [8:0] rdy_exp;
      rdy_exp = 9'b001010101;   // bit k = expected in_ready in cycle k
      cfg_prec = 2'b01; cfg_len = 8'd3;
      in_valid = 1'b1; in_a = 8'd200; in_w = 8'd15;
      for (int k = 0; k < 9; k++) begin
         total++; if (in_ready_a !== rdy_exp[k])
            begin bad++; $display("FAIL t3_ready_cyc%0d got=%b exp=%b", k, in_ready_a, rdy_exp[k]); end
         @(negedge clk);
         if (k == 6) in_valid = 1'b0;
         if (k == 3) begin
            total++; if (busy_a !== 1'b1 || out_valid_a !== 1'b0)
               begin bad++; $display("FAIL t3_busy got busy=%b v=%b exp 1 0", busy_a, out_valid_a); end
         end
      end
      total++; if (out_valid_a !== 1'b1 || out_sum_a !== 24'd12000)
         begin bad++; $display("FAIL t3_result got v=%b sum=%0d exp v=1 sum=12000", out_valid_a, out_sum_a); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // T4: result held under backpressure, then the next vector 3*5 -> 15.
   task automatic test_backpressure();
      cfg_prec = 2'b11; cfg_len = 8'd0;
      in_valid = 1'b1; in_a = 8'd7; in_w = 8'd9;
      @(negedge clk);
      in_a = 8'd3; in_w = 8'd5;   // offered early; must wait until released
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         total++; if ({out_valid_a, in_ready_a} !== 2'b10 || out_sum_a !== 24'd63 || {mult_a_a, mult_w_a} !== 8'h00)
            begin bad++; $display("FAIL t4_hold_cyc%0d got v=%b rdy=%b sum=%0d a=%h w=%h exp v=1 rdy=0 sum=63 0 0", k, out_valid_a, in_ready_a, out_sum_a, mult_a_a, mult_w_a); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1)
         begin bad++; $display("FAIL t4_release got v=%b rdy=%b exp 0 1", out_valid_a, in_ready_a); end
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (mult_a_a !== 4'd3 || mult_w_a !== 4'd5)
         begin bad++; $display("FAIL t4_next_pass got a=%h w=%h exp 3 5", mult_a_a, mult_w_a); end
      @(negedge clk);
      total++; if (out_valid_a !== 1'b1 || out_sum_a !== 24'd15)
         begin bad++; $display("FAIL t4_next_result got v=%b sum=%0d exp v=1 sum=15", out_valid_a, out_sum_a); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // T5: 8x8, two elements 255*255; 16b accumulator wraps to 64514.
   task automatic test_wrap();
      logic [8:0] rdy_exp;
      rdy_exp = 9'b000010001;
      cfg_prec = 2'b00; cfg_len = 8'd1;
      in_valid = 1'b1; in_a = 8'hFF; in_w = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         total++; if (in_ready_a !== rdy_exp[k])
            begin bad++; $display("FAIL t5_ready_cyc%0d got=%b exp=%b", k, in_ready_a, rdy_exp[k]); end
         @(negedge clk);
         if (k == 4) in_valid = 1'b0;
      end
      total++; if (out_valid_b !== 1'b1 || out_sum_b !== 16'd64514)
         begin bad++; $display("FAIL t5_wrap16 got v=%b sum=%0d exp v=1 sum=64514", out_valid_b, out_sum_b); end
      total++; if (out_valid_a !== 1'b1 || out_sum_a !== 24'd130050)
         begin bad++; $display("FAIL t5_nowrap24 got v=%b sum=%0d exp v=1 sum=130050", out_valid_a, out_sum_a); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // T6: reset during PASS, then a vector whose cfg changes mid-way.
   task automatic test_reset_mid();
      cfg_prec = 2'b00; cfg_len = 8'd0;
      in_valid = 1'b1; in_a = 8'hFF; in_w = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      total++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b1)
         begin bad++; $display("FAIL t6_rst_ctrl got v=%b busy=%b rdy=%b exp 0 0 1", out_valid_a, busy_a, in_ready_a); end
      total++; if (out_sum_a !== 24'd0 || out_sum_b !== 16'd0 || {mult_a_a, mult_w_a} !== 8'h00)
         begin bad++; $display("FAIL t6_rst_data got sum=%0d sum16=%0d a=%h w=%h exp 0", out_sum_a, out_sum_b, mult_a_a, mult_w_a); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cfg_prec = 2'b11; cfg_len = 8'd1;
      in_valid = 1'b1; in_a = 8'd3; in_w = 8'd5;
      @(negedge clk);
      in_valid = 1'b0; cfg_prec = 2'b00; cfg_len = 8'd0;
      total++; if (mult_a_a !== 4'd3 || mult_w_a !== 4'd5 || in_ready_a !== 1'b1)
         begin bad++; $display("FAIL t6_e0_pass got a=%h w=%h rdy=%b exp 3 5 1", mult_a_a, mult_w_a, in_ready_a); end
      @(negedge clk);
      total++; if (busy_a !== 1'b1 || in_ready_a !== 1'b1 || out_valid_a !== 1'b0)
         begin bad++; $display("FAIL t6_gap got busy=%b rdy=%b v=%b exp 1 1 0", busy_a, in_ready_a, out_valid_a); end
      in_valid = 1'b1; in_a = 8'd6; in_w = 8'd7;
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (mult_a_a !== 4'd6 || mult_w_a !== 4'd7 || in_ready_a !== 1'b0)
         begin bad++; $display("FAIL t6_e1_pass got a=%h w=%h rdy=%b exp 6 7 0", mult_a_a, mult_w_a, in_ready_a); end
      @(negedge clk);
      total++; if (out_valid_a !== 1'b1 || out_sum_a !== 24'd57)
         begin bad++; $display("FAIL t6_result got v=%b sum=%0d exp v=1 sum=57", out_valid_a, out_sum_a); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0)
         begin bad++; $display("FAIL t6_release got v=%b busy=%b exp 0 0", out_valid_a, busy_a); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_prec4x4();
      test_prec8x8();
      test_back_to_back();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
